apb_completer: RTL and testbench

APB responder for the `apbmaster` initiator. It implements a word-addressed register file of `DEPTH` 32-bit words, plus one read-only transfer counter. It inserts a programmable number of wait states and signals `pslverr` for bad addresses and illegal writes. It sits on the slave side of the APB link and consumes `psel`, `penable`, `paddr`, `pwrite` and `pwdata` directly from the master.

---
 rtl/apb_completer.sv | 147 ++++++++++++++
 tb/tb_apb_completer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_completer.sv
// APB completer: DEPTH-word register file plus a read-only transfer counter at idx DEPTH,
// with WAIT_CYCLES wait states per access and pslverr on bad addresses or counter writes.
module apb_completer #(
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [32:0] paddr,
   input  logic [31:0] pwdata,
   output logic        pready,
   output logic [31:0] prdata,
   output logic        pslverr
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q;
   logic        write_q;
   logic [31:0] wdata_q;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        pready_q, pready_d;
   logic        pslverr_q, pslverr_d;
   logic [31:0] prdata_q, prdata_d;
   logic [31:0] xfer_cnt_q, xfer_cnt_d;
   logic        load;
   logic [31:0] mem_q [DEPTH];

   // With zero wait states the response is formed at the setup edge, before the
   // request is latched, so decode straight from the bus while in IDLE.
   logic [31:0] req_addr;
   logic        req_write;
   logic [29:0] req_idx;
   logic        req_err;
   logic [31:0] rd_word;
   logic [31:0] resp_data;

   assign req_addr  = (state_q == IDLE) ? paddr[31:0] : addr_q;
   assign req_write = (state_q == IDLE) ? pwrite : write_q;
   assign req_idx   = req_addr[31:2];
   assign req_err   = (req_addr[1:0] != 2'b00) || (req_idx > 30'(DEPTH)) ||
                      (req_write && (req_idx == 30'(DEPTH)));
   assign rd_word   = (req_idx < 30'(DEPTH)) ? mem_q[req_idx[IW-1:0]] : xfer_cnt_q;
   assign resp_data = (req_err || req_write) ? 32'd0 : rd_word;

   logic do_commit;
   logic do_write;
   assign do_commit = (state_q == ACCESS) && psel && penable && pready_q;
   assign do_write  = do_commit && write_q && !pslverr_q;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      pready_d   = pready_q;
      pslverr_d  = pslverr_q;
      prdata_d   = prdata_q;
      xfer_cnt_d = xfer_cnt_q;
      load       = 1'b0;
      case (state_q)
         IDLE: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = 32'd0;
            if (psel && !penable) begin
               load    = 1'b1;
               state_d = ACCESS;
               wcnt_d  = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  pready_d  = 1'b1;
                  pslverr_d = req_err;
                  prdata_d  = resp_data;
               end
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d   = IDLE;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = 32'd0;
            end else if (penable) begin
               if (pready_q) begin
                  xfer_cnt_d = xfer_cnt_q + 32'd1;
                  state_d    = IDLE;
                  pready_d   = 1'b0;
                  pslverr_d  = 1'b0;
                  prdata_d   = 32'd0;
               end else if (wcnt_q > 4'd1) begin
                  wcnt_d = wcnt_q - 4'd1;
               end else begin
                  wcnt_d    = 4'd0;
                  pready_d  = 1'b1;
                  pslverr_d = req_err;
                  prdata_d  = resp_data;
               end
            end
            // psel=1, penable=0: stall, everything holds
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q    <= IDLE;
         addr_q     <= 32'd0;
         write_q    <= 1'b0;
         wdata_q    <= 32'd0;
         wcnt_q     <= 4'd0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
         prdata_q   <= 32'd0;
         xfer_cnt_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
         prdata_q   <= prdata_d;
         xfer_cnt_q <= xfer_cnt_d;
         if (load) begin
            addr_q  <= paddr[31:0];
            write_q <= pwrite;
            wdata_q <= pwdata;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
      end else if (do_write) begin
         mem_q[addr_q[IW+1:2]] <= wdata_q;
      end
   end

   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_completer.sv
// Directed bench for apb_completer: one instance with 1 wait state, one with 3,
// sharing the bus; use3 selects which instance sees psel and drives the observed outputs.
module tb_apb_completer;

   logic        pclk = 1'b0;
   logic        preset;
   logic        psel, penable, pwrite;
   logic [32:0] paddr;
   logic [31:0] pwdata;
   logic        use3;

   logic        pready1, pslverr1, pready3, pslverr3;
   logic [31:0] prdata1, prdata3;
   logic        pready, pslverr;
   logic [31:0] prdata;

   always #5 pclk = ~pclk;

   apb_completer #(.DEPTH(16), .WAIT_CYCLES(1)) u_w1 (
      .pclk(pclk), .preset(preset), .psel(psel & ~use3), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pready(pready1), .prdata(prdata1), .pslverr(pslverr1)
   );

   apb_completer #(.DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
      .pclk(pclk), .preset(preset), .psel(psel & use3), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pready(pready3), .prdata(prdata3), .pslverr(pslverr3)
   );

   assign pready  = use3 ? pready3  : pready1;
   assign pslverr = use3 ? pslverr3 : pslverr1;
   assign prdata  = use3 ? prdata3  : prdata1;

   int vectors     = 0;
   int miscompares = 0;
   int exp_cnt [2];
   logic [31:0] model [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Setup at the next falling edge, access from the one after; returns at the
   // falling edge of the pready cycle with the bus still in access phase.
   task automatic xfer(input logic wr, input logic [32:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat);
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      check("setup_ready_low", {31'd0, pready}, 32'd0);
      @(negedge pclk);
      penable = 1'b1;
      pwdata  = ~wd;
      lat = 1;
      while (!pready && lat < 40) begin
         @(negedge pclk);
         lat++;
      end
      rd  = prdata;
      err = pslverr;
      if (pready) exp_cnt[use3 ? 1 : 0]++;
      $display("xfer %s addr=0x%09h wdata=0x%08h -> prdata=0x%08h pslverr=%0b lat=%0d",
               wr ? "WR" : "RD", addr, wd, rd, err, lat);
   endtask

   task automatic idle();
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
      check("ready_drop", {31'd0, pready}, 32'd0);
   endtask

   logic [31:0] rd;
   logic        err;
   int          lat;
   logic [31:0] exp_c;

   initial begin
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      for (int i = 0; i < 16; i++) model[i] = 32'd0;
      use3 = 1'b0;
      preset = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 33'h8; pwdata = 32'h1234_5678;

      // Reset held for two cycles while psel is asserted
      @(negedge pclk);
      @(negedge pclk);
      check("rst_pready", {31'd0, pready1}, 32'd0);
      check("rst_pslverr", {31'd0, pslverr1}, 32'd0);
      check("rst_prdata", prdata1, 32'd0);
      check("rst_pready3", {31'd0, pready3}, 32'd0);
      preset = 1'b0; psel = 1'b0;

      xfer(1'b0, 33'h0, 32'd0, rd, err, lat);
      check("rst_read0", rd, 32'd0);
      check("rst_read0_err", {31'd0, err}, 32'd0);

      // Write then read back, 1 wait state: pready in T2
      xfer(1'b1, 33'h8, 32'hDEAD_BEEF, rd, err, lat);
      check("wr8_lat", lat, 32'd2);
      check("wr8_err", {31'd0, err}, 32'd0);
      check("wr8_prdata", rd, 32'd0);
      model[2] = 32'hDEAD_BEEF;
      xfer(1'b0, 33'h8, 32'd0, rd, err, lat);
      check("rd8", rd, 32'hDEAD_BEEF);
      exp_c = exp_cnt[0];
      xfer(1'b0, 33'h40, 32'd0, rd, err, lat);
      check("rd_cnt", rd, exp_c);
      check("rd_cnt_err", {31'd0, err}, 32'd0);

      // Bad addresses; bit 32 is ignored so it still hits word 2
      xfer(1'b0, 33'h6, 32'd0, rd, err, lat);
      check("misalign_err", {31'd0, err}, 32'd1);
      check("misalign_prdata", rd, 32'd0);
      xfer(1'b1, 33'h44, 32'h5555_AAAA, rd, err, lat);
      check("wr44_err", {31'd0, err}, 32'd1);
      xfer(1'b0, 33'h44, 32'd0, rd, err, lat);
      check("rd44_err", {31'd0, err}, 32'd1);
      check("rd44_prdata", rd, 32'd0);
      xfer(1'b0, 33'h1_0000_0008, 32'd0, rd, err, lat);
      check("bit32_ignored", rd, 32'hDEAD_BEEF);
      xfer(1'b0, 33'h0, 32'd0, rd, err, lat);
      check("wr44_no_change", rd, 32'd0);
      xfer(1'b1, 33'h40, 32'hFFFF_0000, rd, err, lat);
      check("wrcnt_err", {31'd0, err}, 32'd1);
      exp_c = exp_cnt[0];
      xfer(1'b0, 33'h40, 32'd0, rd, err, lat);
      check("cnt_after_err", rd, exp_c);
      idle();

      // Abort: psel dropped in T1 of a write
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 33'h8; pwdata = 32'h1111_1111;
      @(negedge pclk);
      psel = 1'b0;
      check("abort_ready", {31'd0, pready}, 32'd0);
      xfer(1'b0, 33'h8, 32'd0, rd, err, lat);
      check("abort_word", rd, 32'hDEAD_BEEF);
      exp_c = exp_cnt[0];
      xfer(1'b0, 33'h40, 32'd0, rd, err, lat);
      check("abort_cnt", rd, exp_c);

      // Back-to-back writes to every word, no idle gap
      for (int i = 0; i < 16; i++) begin
         model[i] = 32'hA500_0000 + 32'(i) * 32'h0101_0101;
         xfer(1'b1, 33'(i * 4), model[i], rd, err, lat);
         check("b2b_lat", lat, 32'd2);
         check("b2b_err", {31'd0, err}, 32'd0);
      end
      for (int i = 0; i < 16; i++) begin
         xfer(1'b0, 33'(i * 4), 32'd0, rd, err, lat);
         check("b2b_read", rd, model[i]);
      end
      exp_c = exp_cnt[0];
      xfer(1'b0, 33'h40, 32'd0, rd, err, lat);
      check("b2b_cnt", rd, exp_c);
      idle();

      // Three wait states: pready low T1..T3, high in T4, low again in T5
      use3 = 1'b1;
      xfer(1'b1, 33'h10, 32'hCAFE_F00D, rd, err, lat);
      check("w3_lat", lat, 32'd4);
      check("w3_err", {31'd0, err}, 32'd0);
      idle();
      xfer(1'b0, 33'h10, 32'd0, rd, err, lat);
      check("w3_read", rd, 32'hCAFE_F00D);
      check("w3_read_lat", lat, 32'd4);
      exp_c = exp_cnt[1];
      xfer(1'b0, 33'h40, 32'd0, rd, err, lat);
      check("w3_cnt", rd, exp_c);
      idle();

      // Reset in a wait cycle of a write
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 33'h10; pwdata = 32'h7777_7777;
      for (int c = 1; c <= 6; c++) begin
         @(negedge pclk);
         penable = 1'b1;
         preset  = (c == 2);
         check("rstmid_ready", {31'd0, pready}, 32'd0);
      end
      psel = 1'b0; penable = 1'b0;
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      xfer(1'b0, 33'h10, 32'd0, rd, err, lat);
      check("rstmid_word", rd, 32'd0);
      xfer(1'b0, 33'h40, 32'd0, rd, err, lat);
      check("rstmid_cnt", rd, 32'd1);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
